// File: rtl/snn_pkg.sv
// Shared SNN constants and store FSM state encoding.
// Used by the core controller and the output store.
package snn_pkg;

  localparam int NUM_OUTPUTS_DEF = 10;
  localparam int CNT_WIDTH_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STORE,
    ST_DONE
  } store_state_t;

endpackage

// File: rtl/snn_spike_counter.sv
// Saturating spike counter with synchronous clear.
// Clear has priority over a same-cycle increment.
module snn_spike_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // count up to all-ones and stick there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/snn_output_store.sv
// Output spike counting, serial result store and winner tracking.
// Result bank is a resettable register array with a registered read port.
module snn_output_store
  import snn_pkg::*;
#(
  parameter int NUM_OUTPUTS = NUM_OUTPUTS_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int ADDR_WIDTH  = $clog2(NUM_OUTPUTS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   count_clr,
  input  logic                   network_en,
  input  logic [NUM_OUTPUTS-1:0] spike_in,
  input  logic                   output_cntr_rst,
  input  logic                   output_cntr_en,
  output logic                   outputs_done,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [CNT_WIDTH-1:0]   rd_data,
  output logic [ADDR_WIDTH-1:0]  winner_idx,
  output logic                   winner_valid
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
    ADDR_WIDTH'(NUM_OUTPUTS - 1);
  localparam logic [ADDR_WIDTH:0] N_L =
    (ADDR_WIDTH + 1)'(NUM_OUTPUTS);

  logic [CNT_WIDTH-1:0]  cnt [NUM_OUTPUTS];
  logic [CNT_WIDTH-1:0]  mem [NUM_OUTPUTS];
  logic [CNT_WIDTH-1:0]  best_cnt;
  logic [CNT_WIDTH-1:0]  cur_cnt;
  logic [ADDR_WIDTH-1:0] idx;
  store_state_t          state;
  logic                  we;
  logic                  rd_ok;

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_cnt
    snn_spike_counter #(
      .W (CNT_WIDTH)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (count_clr),
      .en    (network_en & spike_in[g]),
      .cnt   (cnt[g])
    );
  end

  assign cur_cnt = cnt[idx];
  assign rd_ok   = {1'b0, rd_addr} < N_L;
  assign we      = (state == ST_STORE) && output_cntr_en &&
                   !output_cntr_rst;

  // store sequencer and winner tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      best_cnt     <= '0;
      outputs_done <= 1'b0;
      winner_idx   <= '0;
      winner_valid <= 1'b0;
    end else if (output_cntr_rst) begin
      state        <= ST_STORE;
      idx          <= '0;
      best_cnt     <= '0;
      outputs_done <= 1'b0;
      winner_valid <= 1'b0;
    end else begin
      case (state)
        ST_STORE: begin
          if (output_cntr_en) begin
            if ((idx == '0) || (cur_cnt > best_cnt)) begin
              best_cnt   <= cur_cnt;
              winner_idx <= idx;
            end
            if (idx == LAST_IDX) begin
              state        <= ST_DONE;
              outputs_done <= 1'b1;
              winner_valid <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // result bank writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= cur_cnt;
    end
  end

  // registered read, old data on same-cycle write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_ok ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_snn_output_store.sv
// Randomized and directed checks of snn_output_store
// against a behavioural model of counts and stored results.
module tb_snn_output_store;

  localparam int N  = 10;
  localparam int CW = 4;
  localparam int AW = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          count_clr;
  logic          network_en;
  logic [N-1:0]  spike_in;
  logic          output_cntr_rst;
  logic          output_cntr_en;
  logic          outputs_done;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] rd_data;
  logic [AW-1:0] winner_idx;
  logic          winner_valid;

  int total = 0;
  int bad   = 0;

  int m_cnt [N];
  int m_mem [N];
  bit m_active;
  bit m_done;
  int m_pos;

  snn_output_store #(
    .NUM_OUTPUTS (N),
    .CNT_WIDTH   (CW),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .count_clr       (count_clr),
    .network_en      (network_en),
    .spike_in        (spike_in),
    .output_cntr_rst (output_cntr_rst),
    .output_cntr_en  (output_cntr_en),
    .outputs_done    (outputs_done),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .winner_idx      (winner_idx),
    .winner_valid    (winner_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int argmax();
    int mx = 0;
    for (int i = 0; i < N; i++) if (m_mem[i] > mx) mx = m_mem[i];
    for (int i = 0; i < N; i++) if (m_mem[i] == mx) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      m_mem[i] = 0;
    end
    m_active = 0;
    m_done   = 0;
    m_pos    = 0;
  endtask

  task automatic tick();
    int rd_exp;
    rd_exp = (int'(rd_addr) < N) ? m_mem[rd_addr] : 0;
    if (output_cntr_rst) begin
      m_active = 1;
      m_pos    = 0;
      m_done   = 0;
    end else if (m_active && output_cntr_en) begin
      m_mem[m_pos] = m_cnt[m_pos];
      m_pos++;
      if (m_pos == N) begin
        m_active = 0;
        m_done   = 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (count_clr) m_cnt[i] = 0;
      else if (network_en && spike_in[i] && m_cnt[i] < MAXC)
        m_cnt[i]++;
    end
    @(posedge clk);
    #1;
    chk("rd_data", rd_data, rd_exp);
    chk("outputs_done", outputs_done, m_done);
    chk("winner_valid", winner_valid, m_done);
    if (m_done) chk("winner_idx", winner_idx, argmax());
  endtask

  task automatic idle_inputs();
    count_clr       = 0;
    network_en      = 0;
    spike_in        = '0;
    output_cntr_rst = 0;
    output_cntr_en  = 0;
  endtask

  task automatic do_store();
    output_cntr_rst = 1;
    tick();
    output_cntr_rst = 0;
    output_cntr_en  = 1;
    for (int k = 0; k < N; k++) begin
      rd_addr = AW'($urandom_range(0, 15));
      tick();
    end
    output_cntr_en = 0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) begin
      rd_addr = AW'(a);
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    rd_addr = '0;
    rst_n   = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_data", rd_data, 0);
    chk("reset_done", outputs_done, 0);
    chk("reset_wvalid", winner_valid, 0);
    rst_n = 1;
    read_all();

    // 3/7/7/1 pattern
    count_clr = 1;
    tick();
    count_clr  = 0;
    network_en = 1;
    for (int k = 0; k < 7; k++) begin
      spike_in = '0;
      spike_in[0] = (k < 3);
      spike_in[1] = 1'b1;
      spike_in[2] = 1'b1;
      spike_in[3] = (k < 1);
      tick();
    end
    idle_inputs();
    do_store();
    chk("tie_winner", winner_idx, 1);
    chk("done_after_10", outputs_done, 1);
    read_all();

    // stall mid-store with overlapping random spikes
    output_cntr_rst = 1;
    tick();
    output_cntr_rst = 0;
    for (int k = 0; k < 15; k++) begin
      output_cntr_en = !(k >= 4 && k < 9);
      network_en     = 1'($urandom_range(0, 1));
      spike_in       = N'($urandom);
      rd_addr        = AW'($urandom_range(0, 15));
      tick();
      if (k < 14) chk("stall_not_done", outputs_done, 0);
    end
    chk("stall_done", outputs_done, 1);
    idle_inputs();
    read_all();

    // saturation on neuron 2
    count_clr = 1;
    tick();
    count_clr  = 0;
    network_en = 1;
    spike_in   = N'(1 << 2);
    repeat (20) tick();
    idle_inputs();
    do_store();
    rd_addr = 2;
    tick();
    chk("saturated", rd_data, 15);

    // clear beats same-cycle spike
    network_en = 1;
    spike_in   = '1;
    tick();
    count_clr = 1;
    tick();
    idle_inputs();
    do_store();
    rd_addr = 5;
    tick();
    chk("clr_wins", rd_data, 0);

    // rst+en same cycle, then async reset at idx 4
    network_en = 1;
    spike_in   = N'($urandom);
    repeat (3) tick();
    idle_inputs();
    output_cntr_rst = 1;
    output_cntr_en  = 1;
    tick();
    output_cntr_rst = 0;
    repeat (4) tick();
    rst_n = 0;
    #2;
    model_reset();
    chk("abort_done", outputs_done, 0);
    chk("abort_rd", rd_data, 0);
    rst_n = 1;
    output_cntr_en = 1;
    read_all();
    output_cntr_en = 0;

    // extra enables in DONE
    network_en = 1;
    spike_in   = N'($urandom);
    repeat (6) tick();
    idle_inputs();
    do_store();
    output_cntr_en = 1;
    network_en     = 1;
    spike_in       = '1;
    repeat (3) tick();
    idle_inputs();
    rd_addr = 9;
    tick();
    chk("done_held", outputs_done, 1);
    output_cntr_rst = 1;
    tick();
    output_cntr_rst = 0;
    chk("done_cleared", outputs_done, 0);

    // random soak
    for (int k = 0; k < 400; k++) begin
      count_clr       = ($urandom_range(0, 30) == 0);
      network_en      = 1'($urandom_range(0, 1));
      spike_in        = N'($urandom);
      output_cntr_rst = ($urandom_range(0, 25) == 0);
      output_cntr_en  = ($urandom_range(0, 3) != 0);
      rd_addr         = AW'($urandom_range(0, 15));
      tick();
    end
    idle_inputs();
    read_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snn_output_store.md
# snn_output_store

Output-side partner of the SNN core controller. It counts output-neuron spikes while the network runs. When the controller pulses `output_cntr_rst` and then holds `output_cntr_en`, it copies the counts serially into a host-readable result bank, tracks the winning neuron, and signals `outputs_done`. It sits between the SNN core's output layer and the host register interface.

## Interface
- `NUM_OUTPUTS`, 10: number of output neurons; must be at least 2.
- `CNT_WIDTH`, 16: width of each spike counter and result word.
- `ADDR_WIDTH`, `$clog2(NUM_OUTPUTS)`: width of the index and read address.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `count_clr`  in  1  one-cycle pulse that clears all spike counters (tied to network start).
- `network_en`  in  1  counting enable while the network runs.
- `spike_in`  in  NUM_OUTPUTS  per-neuron spike strobes, sampled when `network_en`=1.
- `output_cntr_rst`  in  1  restarts the store sequence.
- `output_cntr_en`  in  1  advances the store sequence by one neuron per cycle.
- `outputs_done`  out  1  registered level; high once all counts are stored.
- `rd_addr`  in  ADDR_WIDTH  host read address into the result bank.
- `rd_data`  out  CNT_WIDTH  registered read data.
- `winner_idx`  out  ADDR_WIDTH  index of the neuron with the highest stored count.
- `winner_valid`  out  1  high while `winner_idx` reflects a completed store.

## Operation
- Reset: all counters, result bank, `idx`, `best_cnt`, `outputs_done`, `winner_idx`, `winner_valid` and `rd_data` go to 0; state goes to IDLE.
- Counting runs independently of the FSM:
  - `count_clr`=1 sets every counter to 0; clear wins over a same-cycle spike.
  - Otherwise, when `network_en`=1 and `spike_in[i]`=1, counter i increments.
  - Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- FSM states are IDLE, STORE and DONE.
- `output_cntr_rst`=1 in any state:
  - next state STORE, `idx`←0, `outputs_done`←0, `winner_valid`←0, `best_cnt`←0;
  - takes priority over a same-cycle `output_cntr_en`, and no write occurs that cycle.
- STORE with `output_cntr_en`=1:
  - `mem[idx]`←`cnt[idx]`.
  - If `idx`=0 or `cnt[idx]` > `best_cnt`: `best_cnt`←`cnt[idx]` and `winner_idx`←`idx`. Strict greater-than, so ties go to the lowest index.
  - If `idx`=NUM_OUTPUTS-1: next state DONE, `outputs_done`←1, `winner_valid`←1. Otherwise `idx`←`idx`+1.
- STORE with `output_cntr_en`=0: hold all state; stalls are legal.
- DONE: hold until `output_cntr_rst`. Extra `output_cntr_en` cycles are ignored and cause no writes.
- IDLE: `output_cntr_en` is ignored.
- Read port:
  - `rd_data`←`mem[rd_addr]` every cycle.
  - Same-cycle write to the same address returns the old value (read-before-write).
  - `rd_addr` ≥ NUM_OUTPUTS returns 0.

## Timing
- Store latency: NUM_OUTPUTS enabled cycles after the `output_cntr_rst` cycle. `outputs_done` rises on the edge that performs the last write.
- The controller samples `outputs_done` combinationally. It therefore leaves its store state one cycle after the last write, and that one extra `output_cntr_en` cycle is harmless.
- `rd_data` has one-cycle latency.
- `winner_idx` is updated during STORE but is only qualified by `winner_valid`.
- Reset mid-store aborts immediately: the bank is zeroed and `outputs_done`=0.
- Counting and storing may overlap. Each store write captures the counter value present in that cycle.

## Structure
- `snn_pkg`: store FSM state enum and default `NUM_OUTPUTS`/`CNT_WIDTH` constants shared with the core.
- Sub-module `snn_spike_counter`: one saturating counter with clear, enable and width parameter, instantiated NUM_OUTPUTS times in a generate loop.
- The result bank is a register array, not a BRAM, so it can be reset.

## Test plan
- Reset then read all addresses → `rd_data`=0, `outputs_done`=0, `winner_valid`=0.
- Count 3/7/7/1/0… spikes on neurons 0-3 via `network_en`, then `output_cntr_rst` plus 10 `output_cntr_en` cycles → `mem`={3,7,7,1,0…}, `winner_idx`=1 (tie goes low), `outputs_done` high after the 10th enable.
- Stall test: deassert `output_cntr_en` for 5 cycles mid-store → `idx` and `outputs_done` hold; completion occurs after exactly 10 enabled cycles.
- With CNT_WIDTH=4, apply 20 spikes to neuron 2 → stored value 15 (saturated). Assert `count_clr` in the same cycle as a spike → counter reads 0.
- Assert `output_cntr_rst` and `output_cntr_en` in the same cycle, and pulse `rst_n` at `idx`=4 → no write on the rst cycle; after reset the bank is all zero and the FSM is in IDLE.
- Issue 3 extra `output_cntr_en` cycles in DONE, then read address 9 → value unchanged, `outputs_done` stays 1 until the next `output_cntr_rst`.
